// File: rtl/sad_pkg.sv
// Shared widths and default parameters for the SAD accumulation pipeline.
package sad_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_INPUTS = 4;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_CAND   = 8;

  function automatic int sad_width(input int width, input int inputs, input int rows);
    return width + $clog2(inputs * rows);
  endfunction

  function automatic int idx_width(input int cand);
    return (cand > 1) ? $clog2(cand) : 1;
  endfunction

  function automatic int sum_width(input int width, input int inputs);
    return width + $clog2(inputs);
  endfunction

endpackage

// File: rtl/abs_diff_tree.sv
// Two registered stages: per-lane absolute differences, then their lane sum.
module abs_diff_tree
  import sad_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int INPUTS = DEF_INPUTS,
  localparam int SUMW  = sum_width(WIDTH, INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [WIDTH*INPUTS-1:0] a,
  input  logic [WIDTH*INPUTS-1:0] b,
  output logic                    sum_valid,
  output logic [SUMW-1:0]         sum
);

  logic [INPUTS-1:0][WIDTH-1:0] diff_d;
  logic [INPUTS-1:0][WIDTH-1:0] diff_q;
  logic                         diff_valid;
  logic [SUMW-1:0]              sum_d;

  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      diff_d[i] = (a[i*WIDTH +: WIDTH] > b[i*WIDTH +: WIDTH])
                ? a[i*WIDTH +: WIDTH] - b[i*WIDTH +: WIDTH]
                : b[i*WIDTH +: WIDTH] - a[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    // NOTE: default assigned before the loop so sum_d is driven on every path and no latch is inferred.
    sum_d = '0;
    for (int i = 0; i < INPUTS; i++) begin
      sum_d = sum_d + SUMW'(diff_q[i]);
    end
  end

  // NOTE: non-blocking assignments so each stage captures the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_valid <= 1'b0;
      diff_q     <= '0;
      sum_valid  <= 1'b0;
      sum        <= '0;
    end else if (clear) begin
      diff_valid <= 1'b0;
      sum_valid  <= 1'b0;
    end else if (en) begin
      diff_valid <= in_valid;
      diff_q     <= diff_d;
      sum_valid  <= diff_valid;
      sum        <= sum_d;
    end
  end

endmodule

// File: rtl/sad_accum_pipe.sv
// Block SAD pipeline: lane diff/sum tree, per-block accumulator, result register
// with candidate index and running minimum across a search.
module sad_accum_pipe
  import sad_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int INPUTS = DEF_INPUTS,
  parameter int ROWS   = DEF_ROWS,
  parameter int CAND   = DEF_CAND,
  localparam int SW    = sad_width(WIDTH, INPUTS, ROWS),
  localparam int IW    = idx_width(CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*INPUTS-1:0] a,
  input  logic [WIDTH*INPUTS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SW-1:0]           sad,
  output logic [IW-1:0]           idx,
  output logic                    out_last,
  output logic [SW-1:0]           best_sad,
  output logic [IW-1:0]           best_idx
);

  localparam int SUMW = sum_width(WIDTH, INPUTS);
  localparam int BW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(ROWS - 1);
  localparam logic [IW-1:0] LAST_CAND = IW'(CAND - 1);

  logic            stall;
  logic            en;
  logic            sum_valid;
  logic [SUMW-1:0] sum;
  logic [BW-1:0]   beat_cnt;
  logic [SW-1:0]   acc;
  logic            acc_done;
  logic [IW-1:0]   cand_cnt;
  logic            have_min;
  logic            take_min;
  logic            cand_last;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  abs_diff_tree #(
    .WIDTH  (WIDTH),
    .INPUTS (INPUTS)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum_valid (sum_valid),
    .sum       (sum)
  );

  // First beat of a block loads the accumulator so no explicit zeroing cycle is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      acc      <= '0;
      acc_done <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      acc_done <= 1'b0;
    end else if (en) begin
      acc_done <= 1'b0;
      if (sum_valid) begin
        acc <= (beat_cnt == '0) ? SW'(sum) : acc + SW'(sum);
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          acc_done <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  // Strict less-than keeps the lower index on ties; have_min=0 means the next candidate loads.
  assign take_min  = ~have_min | (acc < best_sad);
  assign cand_last = (cand_cnt == LAST_CAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sad       <= '0;
      idx       <= '0;
      out_last  <= 1'b0;
      best_sad  <= '0;
      best_idx  <= '0;
      cand_cnt  <= '0;
      have_min  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      cand_cnt  <= '0;
      have_min  <= 1'b0;
    end else if (en) begin
      out_valid <= acc_done;
      if (acc_done) begin
        sad      <= acc;
        idx      <= cand_cnt;
        out_last <= cand_last;
        if (take_min) begin
          best_sad <= acc;
          best_idx <= cand_cnt;
        end
        have_min <= ~cand_last;
        cand_cnt <= cand_last ? '0 : cand_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sad_accum_pipe.sv
// Directed bench for sad_accum_pipe: latency, overflow edge, search minimum,
// backpressure, clear and mid-block reset, checked against bench-side values.
module tb_sad_accum_pipe;
  import sad_pkg::*;

  localparam int SW = sad_width(DEF_WIDTH, DEF_INPUTS, DEF_ROWS);
  localparam int IW = idx_width(DEF_CAND);

  typedef struct packed {
    logic [SW-1:0] sad;
    logic [IW-1:0] idx;
    logic          last;
    logic [SW-1:0] bsad;
    logic [IW-1:0] bidx;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sad;
  logic [IW-1:0] idx;
  logic          out_last;
  logic [SW-1:0] best_sad;
  logic [IW-1:0] best_idx;

  int   checks   = 0;
  int   failures = 0;
  int   beat_ticks = 0;
  res_t res_q[$];

  sad_accum_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sad       (sad),
    .idx       (idx),
    .out_last  (out_last),
    .best_sad  (best_sad),
    .best_idx  (best_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1 and +2, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      r.sad  = sad;
      r.idx  = idx;
      r.last = out_last;
      r.bsad = best_sad;
      r.bidx = best_idx;
      res_q.push_back(r);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] av, input logic [31:0] bv);
    logic acc;
    int   n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      beat_ticks++;
      n++;
    end
    if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      tick();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Block whose SAD is s: half on lane 0 (a>b) in beat 0, half on lane 3 (b>a) in beat 2.
  task automatic block_sad(input int s);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'(s - s / 2);
    lo = 32'(s / 2) << 24;
    beat(hi, 32'd0);
    beat(32'd0, 32'd0);
    beat(32'd0, lo);
    beat(32'd0, 32'd0);
  endtask

  task automatic expect_out(input string tag, input int exp_sad, input int exp_idx,
                            input bit exp_last, input int exp_bsad, input int exp_bidx);
    res_t r;
    int   n;
    n = 0;
    while (res_q.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_present"}, 32'(res_q.size() != 0), 32'd1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      check({tag, "_sad"}, 32'(r.sad), 32'(exp_sad));
      check({tag, "_idx"}, 32'(r.idx), 32'(exp_idx));
      check({tag, "_last"}, 32'(r.last), 32'(exp_last));
      if (exp_last) begin
        check({tag, "_best_sad"}, 32'(r.bsad), 32'(exp_bsad));
        check({tag, "_best_idx"}, 32'(r.bidx), 32'(exp_bidx));
      end
    end
  endtask

  function automatic int beat_sad(input logic [31:0] av, input logic [31:0] bv);
    int s;
    int x;
    int y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = int'(av[i*8 +: 8]);
      y = int'(bv[i*8 +: 8]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  initial begin
    int srch_sads[8];
    int rnd_sads[8];
    int min_s;
    int min_i;
    logic [31:0] av;
    logic [31:0] bv;

    srch_sads = '{50, 30, 30, 70, 20, 20, 90, 40};
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sad", 32'(sad), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_best_sad", 32'(best_sad), 32'd0);
    check("rst_best_idx", 32'(best_idx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Uniform block: 4 lanes x 3 x 4 beats = 48, out_valid exactly 3 cycles after the last accept.
    for (int r = 0; r < 4; r++) beat(32'h0A0A0A0A, 32'h07070707);
    in_valid = 1'b0;
    check("lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3", 32'(out_valid), 32'd1);
    check("lat_sad", 32'(sad), 32'd48);
    check("lat_idx", 32'(idx), 32'd0);
    expect_out("blk0", 48, 0, 1'b0, 0, 0);

    // Full-swing lanes: 1020 per beat, 4080 per block, still fits in SW bits.
    for (int r = 0; r < 4; r++) beat(32'hFF00FF00, 32'h00FF00FF);
    idle(1);
    expect_out("wide", 4080, 1, 1'b0, 0, 0);

    // Small SAD on idx 2 would win the next search unless clear re-arms the minimum.
    block_sad(5);
    idle(1);
    expect_out("blk2", 5, 2, 1'b0, 0, 0);

    beat(32'h11111111, 32'h00000000);
    beat(32'h22222222, 32'h00000000);
    clear = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'h00000000;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    idle(8);
    check("clr_no_output", 32'(res_q.size()), 32'd0);
    check("clr_out_valid_idle", 32'(out_valid), 32'd0);

    // Eight back-to-back candidates at one beat per cycle; ties keep the lower idx.
    beat_ticks = 0;
    for (int k = 0; k < 8; k++) block_sad(srch_sads[k]);
    check("throughput_ticks", 32'(beat_ticks), 32'd32);
    idle(1);
    for (int k = 0; k < 8; k++)
      expect_out($sformatf("srch%0d", k), srch_sads[k], k, k == 7, 20, 4);

    // Backpressure: hold out_ready low for 5 cycles with the pipe filling behind.
    out_ready = 1'b0;
    fork
      begin
        block_sad(11);
        block_sad(22);
        block_sad(33);
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
          @(posedge clk);
          #2;
          n++;
        end
        check("stall_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("stall_ready%0d", i), 32'(in_ready), 32'd0);
          check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
          check($sformatf("stall_sad%0d", i), 32'(sad), 32'd11);
          check($sformatf("stall_idx%0d", i), 32'(idx), 32'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    idle(1);
    expect_out("bp0", 11, 0, 1'b0, 0, 0);
    expect_out("bp1", 22, 1, 1'b0, 0, 0);
    expect_out("bp2", 33, 2, 1'b0, 0, 0);
    idle(4);
    check("bp_no_extra", 32'(res_q.size()), 32'd0);

    // Mid-block asynchronous reset with in_valid held high.
    beat($urandom, $urandom);
    bubble(1);
    beat($urandom, $urandom);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_sad", 32'(sad), 32'd0);
    check("arst_idx", 32'(idx), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_best_sad", 32'(best_sad), 32'd0);
    check("arst_best_idx", 32'(best_idx), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random search with random bubbles, compared to a bench-side SAD and minimum model.
    for (int k = 0; k < 8; k++) begin
      rnd_sads[k] = 0;
      for (int r = 0; r < 4; r++) begin
        av = $urandom;
        bv = $urandom;
        rnd_sads[k] += beat_sad(av, bv);
        if ($urandom_range(0, 2) == 0) bubble(int'($urandom_range(1, 3)));
        beat(av, bv);
      end
    end
    idle(1);
    min_s = 0;
    min_i = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0 || rnd_sads[k] < min_s) begin
        min_s = rnd_sads[k];
        min_i = k;
      end
      expect_out($sformatf("rnd%0d", k), rnd_sads[k], k, k == 7, min_s, min_i);
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
